// File: rtl/datapath_pkg.sv
// Shared encodings for the multicycle MIPS-subset datapath and its control unit.
package datapath_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_fn_e;

  function automatic logic [DATA_W-1:0] sign_ext(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// ALU with its ALU-control decode (ALUOp + funct -> operation), plus zero flag.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  alu_fn_e                  fn;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = op_a;
  assign b_s = op_b;

  always_comb begin
    fn = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: fn = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SUB: fn = ALU_SUB;
          FUNCT_AND: fn = ALU_AND;
          FUNCT_OR:  fn = ALU_OR;
          FUNCT_SLT: fn = ALU_SLT;
          default:   fn = ALU_ADD;
        endcase
      end
      default: fn = ALU_ADD;
    endcase
  end

  always_comb begin
    result = '0;
    case (fn)
      ALU_SUB: result = op_a - op_b;
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      default: result = op_a + op_b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath (lw/sw/R-type/beq/j) driven by an external control word.
// Optional DATAPATH_DEBUG_PORT_EN adds dbg_raddr/dbg_rdata/dbg_pc observation ports.
module multicycle_datapath
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic        MemtoReg,
  input  logic        ALUSrcA,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic [1:0]  PCSource,
  input  logic [1:0]  ALUOp,
  input  logic [1:0]  ALUSrcB,
  output logic [5:0]  Op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
`ifdef DATAPATH_DEBUG_PORT_EN
  ,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic [31:0] dbg_pc
`endif
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic [DATA_W-1:0] rf_q [32];

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              pc_en;

  datapath_alu u_alu (
    .alu_op (ALUOp),
    .funct  (ir_q[5:0]),
    .op_a   (alu_a),
    .op_b   (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    imm_sext = sign_ext(ir_q[15:0]);
    alu_a    = ALUSrcA ? a_q : pc_q;
    alu_b    = b_q;
    case (ALUSrcB)
      SRCB_FOUR:    alu_b = 32'd4;
      SRCB_IMM:     alu_b = imm_sext;
      SRCB_IMM_SH2: alu_b = {imm_sext[DATA_W-3:0], 2'b00};
      default:      alu_b = b_q;
    endcase
  end

  // PC source: jump target uses the already-incremented PC's upper nibble.
  always_comb begin
    pc_en = PCWrite | (PCWriteCond & alu_zero);
    pc_d  = pc_q;
    if (pc_en) begin
      case (PCSource)
        PCSRC_ALU:    pc_d = alu_result;
        PCSRC_ALUOUT: pc_d = alu_out_q;
        PCSRC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        default:      pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    ir_d      = IRWrite ? mem_rdata : ir_q;
    mdr_d     = mem_rdata;
    a_d       = rf_q[ir_q[25:21]];
    b_d       = rf_q[ir_q[20:16]];
    alu_out_d = alu_result;
    rf_waddr  = RegDst ? ir_q[15:11] : ir_q[20:16];
    rf_wdata  = MemtoReg ? mdr_q : alu_out_q;
    rf_we     = RegWrite && (rf_waddr != '0);
  end

  // $0 is never written, so its reset value of zero holds forever.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      if (rf_we) begin
        rf_q[rf_waddr] <= rf_wdata;
      end
    end
  end

  assign Op        = ir_q[31:26];
  assign mem_addr  = IorD ? alu_out_q : pc_q;
  assign mem_wdata = b_q;
  assign mem_read  = MemRead;
  assign mem_write = MemWrite;

`ifdef DATAPATH_DEBUG_PORT_EN
  assign dbg_rdata = rf_q[dbg_raddr];
  assign dbg_pc    = pc_q;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench: an ISA-level model predicts fetch addresses and store traffic.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [5:0]  Op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
`ifdef DATAPATH_DEBUG_PORT_EN
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata, dbg_pc;
`endif

  always #5 clk = ~clk;

  multicycle_datapath dut (
    .clk(clk), .reset_n(reset_n),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .Op(Op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
`ifdef DATAPATH_DEBUG_PORT_EN
    , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .dbg_pc(dbg_pc)
`endif
  );

  logic [31:0] tb_mem [0:255];
  assign mem_rdata = tb_mem[mem_addr[9:2]];

  // Reference model state
  logic [31:0] m_mem [0:255];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_pc;
  logic [31:0] q_fetch [$];
  logic [63:0] q_st [$];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: compare every fetch and every store against the scoreboard
  logic [31:0] mon_e;
  logic [63:0] mon_s;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (MemRead && IRWrite && !IorD) begin
        if (q_fetch.size() == 0) begin
          total++; bad++;
          $display("FAIL fetch_unexpected: got addr %08h expected no fetch", mem_addr);
        end else begin
          mon_e = q_fetch.pop_front();
          check("fetch_pc", mem_addr, mon_e);
        end
      end
      if (mem_write) begin
        if (q_st.size() == 0) begin
          total++; bad++;
          $display("FAIL store_unexpected: got addr %08h expected no store", mem_addr);
        end else begin
          mon_s = q_st.pop_front();
          check("store_addr", mem_addr, mon_s[63:32]);
          check("store_data", mem_wdata, mon_s[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 32'd0;
      m_mem[i]  = 32'd0;
    end
  endtask

  task automatic mem_put(input logic [31:0] addr, input logic [31:0] w);
    tb_mem[addr[9:2]] = w;
    m_mem[addr[9:2]]  = w;
  endtask

  // ISA-level execution of one instruction
  task automatic model_step(output logic [5:0] op);
    logic [31:0] instr, a, b, imm, addr, res;
    logic [4:0]  rs, rt, rd;
    instr = m_mem[m_pc[9:2]];
    q_fetch.push_back(m_pc);
    m_pc = m_pc + 32'd4;
    op   = instr[31:26];
    rs   = instr[25:21];
    rt   = instr[20:16];
    rd   = instr[15:11];
    imm  = {{16{instr[15]}}, instr[15:0]};
    a    = m_reg[rs];
    b    = m_reg[rt];
    addr = a + imm;
    case (op)
      6'h23: if (rt != 5'd0) m_reg[rt] = m_mem[addr[9:2]];
      6'h2B: begin
        q_st.push_back({addr, b});
        m_mem[addr[9:2]] = b;
      end
      6'h00: begin
        case (instr[5:0])
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: res = a + b;
        endcase
        if (rd != 5'd0) m_reg[rd] = res;
      end
      6'h04: if (a == b) m_pc = m_pc + (imm << 2);
      6'h02: m_pc = {m_pc[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  endtask

  task automatic clr_cw();
    PCWrite = 0; PCWriteCond = 0; IorD = 0; MemRead = 0; MemWrite = 0;
    IRWrite = 0; MemtoReg = 0; ALUSrcA = 0; RegWrite = 0; RegDst = 0;
    PCSource = 2'b11; ALUOp = 2'b00; ALUSrcB = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch();
    clr_cw();
    MemRead = 1; IRWrite = 1; ALUSrcB = 2'b01; PCWrite = 1; PCSource = 2'b00;
    tick();
  endtask

  task automatic do_decode(input logic [5:0] exp_op);
    clr_cw();
    ALUSrcB = 2'b11;
    check("decode_op", {26'd0, Op}, {26'd0, exp_op});
    tick();
  endtask

  task automatic run_instr();
    logic [5:0] op;
    model_step(op);
    do_fetch();
    do_decode(op);
    case (op)
      6'h23: begin
        clr_cw(); ALUSrcA = 1; ALUSrcB = 2'b10; tick();
        MemRead = 1; IorD = 1; tick();
        clr_cw(); RegWrite = 1; MemtoReg = 1; tick();
      end
      6'h2B: begin
        clr_cw(); ALUSrcA = 1; ALUSrcB = 2'b10; tick();
        MemWrite = 1; IorD = 1;
        @(negedge clk);
        tb_mem[mem_addr[9:2]] = mem_wdata;
        tick();
      end
      6'h00: begin
        clr_cw(); ALUSrcA = 1; ALUOp = 2'b10; tick();
        clr_cw(); RegWrite = 1; RegDst = 1; tick();
      end
      6'h04: begin
        clr_cw(); ALUSrcA = 1; ALUOp = 2'b01; PCWriteCond = 1; PCSource = 2'b01; tick();
      end
      6'h02: begin
        clr_cw(); PCWrite = 1; PCSource = 2'b10; tick();
      end
      default: ;
    endcase
    clr_cw();
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_instr();
  endtask

  task automatic do_reset();
    clr_cw();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    model_reset();
  endtask

  logic [5:0]  rop;
  logic [31:0] w;
  logic [31:0] pc_addr;
  logic [5:0]  functs [0:5];

  initial begin
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
    functs[3] = 6'h25; functs[4] = 6'h2A; functs[5] = 6'h21;
`ifdef DATAPATH_DEBUG_PORT_EN
    dbg_raddr = 5'd0;
`endif
    clr_cw();
    reset_n = 1'b0;
    mem_clear();
    model_reset();
    #2;
    check("reset_op", {26'd0, Op}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);

    // lw $9,4($0) reading 0xDEADBEEF, then sw $9,8($0) placed at PC 4
    mem_put(32'h0, 32'h8C090004);
    mem_put(32'h4, 32'hDEADBEEF);
    do_reset();
    run_n(1);
`ifdef DATAPATH_DEBUG_PORT_EN
    dbg_raddr = 5'd9;
    #1;
    check("dbg_rdata_r9", dbg_rdata, m_reg[9]);
    check("dbg_pc_after_lw", dbg_pc, 32'h4);
`endif
    mem_put(32'h4, 32'hAC090008);
    run_n(1);

    // R-type, slt and writes to $0
    mem_clear();
    mem_put(32'h00, 32'h8C010100);
    mem_put(32'h04, 32'h8C020104);
    mem_put(32'h08, 32'h00221820);
    mem_put(32'h0C, 32'h0041202A);
    mem_put(32'h10, 32'h00220020);
    mem_put(32'h14, 32'hAC030008);
    mem_put(32'h18, 32'hAC040108);
    mem_put(32'h1C, 32'hAC00010C);
    mem_put(32'h100, 32'd5);
    mem_put(32'h104, 32'd7);
    do_reset();
    run_n(8);

    // beq at PC 8, taken and not taken
    for (int k = 0; k < 2; k++) begin
      mem_clear();
      mem_put(32'h00, 32'h8C010100);
      mem_put(32'h04, 32'h8C020104);
      mem_put(32'h08, 32'h10220002);
      mem_put(32'h0C, 32'hAC02010C);
      mem_put(32'h10, 32'hAC010110);
      mem_put(32'h14, 32'hAC010108);
      mem_put(32'h100, 32'd3);
      mem_put(32'h104, (k == 0) ? 32'd3 : 32'd4);
      do_reset();
      run_n(4);
    end

    // j at PC 0x10 to 0x40
    mem_clear();
    mem_put(32'h00, 32'h8C050100);
    mem_put(32'h04, 32'h8C060104);
    mem_put(32'h08, 32'h00A63822);
    mem_put(32'h0C, 32'h00A64025);
    mem_put(32'h10, 32'h08000010);
    mem_put(32'h40, 32'hAC070108);
    mem_put(32'h44, 32'hAC08010C);
    mem_put(32'h100, $urandom);
    mem_put(32'h104, $urandom);
    do_reset();
    run_n(5);
`ifdef DATAPATH_DEBUG_PORT_EN
    check("dbg_pc_after_j", dbg_pc, 32'h40);
`endif
    run_n(2);

    // Randomized programs: load, random ALU ops, store everything back
    for (int rnd = 0; rnd < 4; rnd++) begin
      mem_clear();
      pc_addr = 32'h0;
      for (int i = 0; i < 8; i++) begin
        w = $urandom | 32'h1;
        mem_put(32'h100 + 32'(4 * i), w);
        mem_put(pc_addr, 32'h8C000000 | (32'(i + 1) << 16) | (32'h100 + 32'(4 * i)));
        pc_addr = pc_addr + 32'd4;
      end
      for (int i = 0; i < 10; i++) begin
        w = (32'($urandom_range(0, 8)) << 21) | (32'($urandom_range(0, 8)) << 16) |
            (32'($urandom_range(0, 12)) << 11) | {26'd0, functs[$urandom_range(0, 5)]};
        mem_put(pc_addr, w);
        pc_addr = pc_addr + 32'd4;
      end
      for (int r = 0; r < 13; r++) begin
        mem_put(pc_addr, 32'hAC000000 | (32'(r) << 16) | (32'h180 + 32'(4 * r)));
        pc_addr = pc_addr + 32'd4;
      end
      do_reset();
      run_n(31);
    end

    // Reset two cycles into an lw; registers hold random data beforehand
    mem_put(m_pc, 32'h8C090004);
    model_step(rop);
    do_fetch();
    do_decode(rop);
    reset_n = 1'b0;
    MemRead = 1; MemWrite = 1;
    #2;
    check("midreset_op", {26'd0, Op}, 32'd0);
    check("midreset_mem_addr", mem_addr, 32'd0);
    check("midreset_mem_wdata", mem_wdata, 32'd0);
    check("midreset_mem_read", {31'd0, mem_read}, 32'd1);
    check("midreset_mem_write", {31'd0, mem_write}, 32'd1);
`ifdef DATAPATH_DEBUG_PORT_EN
    check("midreset_dbg_pc", dbg_pc, 32'd0);
`endif
    clr_cw();
    tick();
    reset_n = 1'b1;
    model_reset();
    mem_clear();
    for (int r = 1; r < 32; r++) begin
      mem_put(32'(4 * (r - 1)), 32'hAC000000 | (32'(r) << 16) | (32'h200 + 32'(4 * r)));
    end
    run_n(31);

    tick();
    check("fetch_queue_drained", 32'(q_fetch.size()), 32'd0);
    check("store_queue_drained", 32'(q_st.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
